// File: rtl/axi_cdc_chan_src.sv
// Source (write) half of a gray-pointer clock-domain-crossing FIFO for one AXI channel.
// Defining AXI_CDC_CHAN_SRC_FILL_LEVEL_EN adds the src_fill_o occupancy output.
module axi_cdc_chan_src #(
    parameter type         chan_t     = logic,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic                          src_clk_i,
    input  logic                          src_rst_ni,
    input  chan_t                         src_data_i,
    input  logic                          src_valid_i,
    output logic                          src_ready_o,
    output chan_t [2**LogDepth-1:0]       async_data_o,
    output logic  [LogDepth:0]            async_wptr_o,
    input  logic  [LogDepth:0]            async_rptr_i
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
    ,
    output logic  [LogDepth:0]            src_fill_o
`endif
);

    localparam int unsigned Depth = 2**LogDepth;

    // Valid/ready: a beat transfers on the rising edge where src_valid_i && src_ready_o.
    // src_ready_o is derived from flops only and never looks at src_valid_i.
    logic                                push;
    logic                                full;
    logic [LogDepth:0]                   wptr_bin_q, wptr_bin_d;
    logic [LogDepth:0]                   wptr_gray_q, wptr_gray_d;
    chan_t [Depth-1:0]                   data_q, data_d;
    logic [SyncStages-1:0][LogDepth:0]   rptr_sync_q, rptr_sync_d;
    logic [LogDepth:0]                   rptr_sync;
    logic [LogDepth:0]                   rptr_flip;

    assign rptr_sync = rptr_sync_q[SyncStages-1];

    // Full when the write pointer is exactly one lap ahead: gray top two bits inverted.
    always_comb begin
        rptr_flip             = rptr_sync;
        rptr_flip[LogDepth]   = ~rptr_sync[LogDepth];
        rptr_flip[LogDepth-1] = ~rptr_sync[LogDepth-1];
    end

    assign full        = (wptr_gray_q == rptr_flip);
    assign src_ready_o = !full;
    assign push        = src_valid_i && src_ready_o;

    always_comb begin
        wptr_bin_d  = wptr_bin_q;
        wptr_gray_d = wptr_gray_q;
        data_d      = data_q;
        if (push) begin
            wptr_bin_d  = wptr_bin_q + 1'b1;
            wptr_gray_d = (wptr_bin_d >> 1) ^ wptr_bin_d;
            data_d[wptr_bin_q[LogDepth-1:0]] = src_data_i;
        end
        rptr_sync_d = {rptr_sync_q[SyncStages-2:0], async_rptr_i};
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            data_q      <= '0;
            rptr_sync_q <= '0;
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
            data_q      <= data_d;
            rptr_sync_q <= rptr_sync_d;
        end
    end

    assign async_data_o = data_q;
    assign async_wptr_o = wptr_gray_q;

`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
    function automatic logic [LogDepth:0] gray2bin(input logic [LogDepth:0] g);
        logic [LogDepth:0] b;
        b = g;
        for (int unsigned i = 1; i <= LogDepth; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Pessimistic: the read pointer is stale by the synchronizer latency.
    assign src_fill_o = wptr_bin_q - gray2bin(rptr_sync);
`endif

endmodule

// File: tb/tb_axi_cdc_chan_src.sv
// Self-checking bench for axi_cdc_chan_src (LogDepth=2, SyncStages=2, 8-bit beats).
module tb_axi_cdc_chan_src;
  localparam int LD    = 2;
  localparam int SS    = 2;
  localparam int DEPTH = 4;
  typedef logic [7:0] beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  beat_t                 src_data;
  logic                  src_valid;
  logic                  src_ready;
  beat_t [DEPTH-1:0]     async_data;
  logic [LD:0]           async_wptr;
  logic [LD:0]           async_rptr;
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
  logic [LD:0]           src_fill;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model: unbounded write/read counts, expected storage, sync pipeline.
  beat_t mem[DEPTH];
  int    wr_cnt;
  int    rd_cnt;
  int    rd_pipe[$];
  logic [7:0] exp_q[$];

  axi_cdc_chan_src #(
    .chan_t(beat_t),
    .LogDepth(LD),
    .SyncStages(SS)
  ) dut (
    .src_clk_i(clk),
    .src_rst_ni(rst_n),
    .src_data_i(src_data),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .async_data_o(async_data),
    .async_wptr_o(async_wptr),
    .async_rptr_i(async_rptr)
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
    ,
    .src_fill_o(src_fill)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] gray_of(input int n);
    int m;
    m = n % 8;
    return 3'(m ^ (m >> 1));
  endfunction

  function automatic int rd_visible();
    return rd_pipe[0];
  endfunction

  function automatic logic model_ready();
    return (wr_cnt - rd_visible()) < DEPTH;
  endfunction

  task automatic set_rd(input int n);
    rd_cnt     = n;
    async_rptr = gray_of(n);
  endtask

  task automatic model_reset();
    wr_cnt = 0;
    rd_pipe.delete();
    for (int i = 0; i < SS; i++) rd_pipe.push_back(0);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    exp_q.delete();
    set_rd(0);
  endtask

  // One clock: model follows the edge, then returns at the falling edge for checks/drive.
  task automatic cycle();
    @(posedge clk);
    if (src_valid && model_ready()) begin
      mem[wr_cnt % DEPTH] = src_data;
      wr_cnt++;
    end
    rd_pipe.push_back(rd_cnt);
    if (rd_pipe.size() > SS) void'(rd_pipe.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    src_valid = 1'b0;
    src_data  = '0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++; if (async_wptr !== 3'b000) begin fails++; $display("FAIL reset_wptr: got %b expected 000", async_wptr); end
    checks++; if (src_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", src_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (async_data[i] !== 8'h00) begin fails++; $display("FAIL reset_data[%0d]: got %h expected 00", i, async_data[i]); end
    end
  endtask

  task automatic test_fill_to_full();
    logic [2:0] seq[4];
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b010; seq[3] = 3'b110;
    set_rd(0);
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = 8'hA0 + 8'(i);
      cycle();
      checks++; if (async_wptr !== seq[i]) begin fails++; $display("FAIL fill_wptr beat %0d: got %b expected %b", i, async_wptr, seq[i]); end
      checks++; if (src_ready !== (i < 3)) begin fails++; $display("FAIL fill_ready beat %0d: got %b expected %b", i, src_ready, (i < 3)); end
    end
    src_data = 8'hA4;
    repeat (2) cycle();
    checks++; if (async_wptr !== 3'b110) begin fails++; $display("FAIL fill_blocked_wptr: got %b expected 110", async_wptr); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (async_data[i] !== 8'hA0 + 8'(i)) begin fails++; $display("FAIL fill_data[%0d]: got %h expected %h", i, async_data[i], 8'hA0 + 8'(i)); end
    end
    src_valid = 1'b0;
  endtask

  task automatic test_blocked_stability();
    for (int c = 0; c < 5; c++) begin
      src_valid = 1'b1;
      src_data  = 8'($urandom_range(0, 255));
      cycle();
      checks++; if (async_wptr !== gray_of(wr_cnt)) begin fails++; $display("FAIL blocked_wptr cyc %0d: got %b expected %b", c, async_wptr, gray_of(wr_cnt)); end
      checks++; if (src_ready !== 1'b0) begin fails++; $display("FAIL blocked_ready cyc %0d: got %b expected 0", c, src_ready); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++; if (async_data[i] !== mem[i]) begin fails++; $display("FAIL blocked_data[%0d]: got %h expected %h", i, async_data[i], mem[i]); end
      end
    end
    src_valid = 1'b0;
  endtask

  task automatic test_release();
    beat_t d;
    set_rd(1);
    cycle();
    checks++; if (src_ready !== 1'b0) begin fails++; $display("FAIL release_edge1_ready: got %b expected 0", src_ready); end
    cycle();
    checks++; if (src_ready !== 1'b1) begin fails++; $display("FAIL release_edge2_ready: got %b expected 1", src_ready); end
    d = 8'($urandom_range(0, 255));
    src_valid = 1'b1;
    src_data  = d;
    cycle();
    src_valid = 1'b0;
    checks++; if (async_data[0] !== d) begin fails++; $display("FAIL release_data0: got %h expected %h", async_data[0], d); end
    checks++; if (async_wptr !== 3'b111) begin fails++; $display("FAIL release_wptr: got %b expected 111", async_wptr); end
    checks++; if (src_ready !== 1'b0) begin fails++; $display("FAIL release_refull_ready: got %b expected 0", src_ready); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (async_wptr !== 3'b000) begin fails++; $display("FAIL async_rst_wptr: got %b expected 000", async_wptr); end
    checks++; if (src_ready !== 1'b1) begin fails++; $display("FAIL async_rst_ready: got %b expected 1", src_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (async_data[i] !== 8'h00) begin fails++; $display("FAIL async_rst_data[%0d]: got %h expected 00", i, async_data[i]); end
    end
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
    checks++; if (src_fill !== 3'd0) begin fails++; $display("FAIL async_rst_fill: got %0d expected 0", src_fill); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src_valid = 1'b1;
      src_data  = 8'($urandom_range(0, 255));
      cycle();
    end
    src_valid = 1'b0;
    checks++; if (async_wptr !== 3'b011) begin fails++; $display("FAIL post_rst_wptr: got %b expected 011", async_wptr); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (async_data[i] !== mem[i]) begin fails++; $display("FAIL post_rst_data[%0d]: got %h expected %h", i, async_data[i], mem[i]); end
    end
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
    checks++; if (src_fill !== 3'd2) begin fails++; $display("FAIL post_rst_fill: got %0d expected 2", src_fill); end
`endif
  endtask

  task automatic test_wrap_around();
    int hist[$];
    int prev;
    logic seen_wrap;
    seen_wrap = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    src_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && rd_cnt < 12; cyc++) begin
      // far side consumes up to the write count it saw three cycles ago
      hist.push_back(wr_cnt);
      if (hist.size() > 3) begin
        int tgt;
        tgt = hist.pop_front();
        while (rd_cnt < tgt) begin
          logic [7:0] exp;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++; if (async_data[rd_cnt % DEPTH] !== exp) begin fails++; $display("FAIL wrap_data beat %0d: got %h expected %h", rd_cnt, async_data[rd_cnt % DEPTH], exp); end
          rd_cnt++;
        end
        set_rd(rd_cnt);
      end
      if (!src_valid && wr_cnt < 12 && $urandom_range(0, 3) != 0) begin
        src_valid = 1'b1;
        src_data  = 8'($urandom_range(0, 255));
      end
      prev = wr_cnt;
      cycle();
      if (wr_cnt != prev) begin
        exp_q.push_back(src_data);
        src_valid = 1'b0;
      end
      checks++; if (async_wptr !== gray_of(wr_cnt)) begin fails++; $display("FAIL wrap_wptr cyc %0d: got %b expected %b", cyc, async_wptr, gray_of(wr_cnt)); end
      checks++; if (src_ready !== model_ready()) begin fails++; $display("FAIL wrap_ready cyc %0d: got %b expected %b", cyc, src_ready, model_ready()); end
`ifdef AXI_CDC_CHAN_SRC_FILL_LEVEL_EN
      checks++; if (src_fill !== 3'(wr_cnt - rd_visible())) begin fails++; $display("FAIL wrap_fill cyc %0d: got %0d expected %0d", cyc, src_fill, wr_cnt - rd_visible()); end
`endif
      if (prev == 7 && wr_cnt == 8) begin
        seen_wrap = 1'b1;
        checks++; if (async_wptr !== 3'b000) begin fails++; $display("FAIL wrap_100_to_000: got %b expected 000", async_wptr); end
      end
    end
    checks++; if (rd_cnt !== 12) begin fails++; $display("FAIL wrap_drained: got %0d beats read expected 12", rd_cnt); end
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL wrap_leftover: got %0d beats left expected 0", exp_q.size()); end
    checks++; if (seen_wrap !== 1'b1) begin fails++; $display("FAIL wrap_seen: got %b expected 1", seen_wrap); end
  endtask

  initial begin
    src_valid  = 1'b0;
    src_data   = '0;
    async_rptr = '0;
    rst_n      = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_to_full();
    test_blocked_stability();
    test_release();
    test_async_reset();
    test_wrap_around();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
